// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: FSM encodings and default widths.
package pwm_pkg;

    // Default width of the period/duty values and the tick counter.
    localparam int DEFAULT_CNT_WIDTH = 8;

    // Generator state. STOP finishes the current period before dropping to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_gen_if.sv
// Configuration channel for pwm_gen: valid/ready transfer of period and duty.
interface pwm_gen_if
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) ();

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CNT_WIDTH-1:0] cfg_period;
    logic [CNT_WIDTH-1:0] cfg_duty;

    // The configuration source offers values and waits for ready.
    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_duty,
        input  cfg_ready
    );

    // The PWM generator accepts values when its shadow slot is free.
    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_duty,
        output cfg_ready
    );

endinterface : pwm_gen_if

// File: rtl/pwm_gen_tick_edge_det.sv
// Rising-edge detector for a divider output that is already registered in clk.
// Emits a one-cycle pulse in the same cycle tick_in is first seen high.
module tick_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic tick_pulse
);

    logic tick_prev_d;
    logic tick_prev_q;

    assign tick_prev_d = tick_in;

    // Remember last cycle's level of tick_in.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_prev_q <= 1'b0;
        end else begin
            tick_prev_q <= tick_prev_d;
        end
    end

    assign tick_pulse = tick_in & ~tick_prev_q;

endmodule : tick_edge_det

// File: rtl/pwm_gen.sv
// PWM generator clocked by clk, advanced by rising edges of the divider tick.
// Period and duty arrive through a one-deep shadow slot and are committed only
// while idle or at a period wrap, so a running waveform never glitches.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick_in,
    input  logic      enable,
    pwm_gen_if.slave  cfg,
    output logic      pwm_out,
    output logic      period_done,
    output logic      busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic tick;

    pwm_state_e           state_d,       state_q;
    logic [CNT_WIDTH-1:0] counter_d,     counter_q;
    logic [CNT_WIDTH-1:0] act_period_d,  act_period_q;
    logic [CNT_WIDTH-1:0] act_duty_d,    act_duty_q;
    logic [CNT_WIDTH-1:0] pend_period_d, pend_period_q;
    logic [CNT_WIDTH-1:0] pend_duty_d,   pend_duty_q;
    logic                 pend_valid_d,  pend_valid_q;
    logic                 pwm_out_d,     pwm_out_q;
    logic                 period_done_d, period_done_q;

    // Values that take effect if a commit happens this cycle.
    logic [CNT_WIDTH-1:0] eff_period;
    logic [CNT_WIDTH-1:0] eff_duty;
    logic [CNT_WIDTH-1:0] wrap_cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 cfg_xfer;

    tick_edge_det u_tick_edge_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .tick_pulse (tick)
    );

    assign eff_period = pend_valid_q ? pend_period_q : act_period_q;
    assign eff_duty   = pend_valid_q ? pend_duty_q   : act_duty_q;
    assign wrap_cnt   = act_period_q - CNT_ONE;
    assign cnt_inc    = counter_q + CNT_ONE;
    assign cfg_xfer   = cfg.cfg_valid && !pend_valid_q;

    // Next-state logic for the FSM, counter, shadow registers and outputs.
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        act_period_d  = act_period_q;
        act_duty_d    = act_duty_q;
        pend_period_d = pend_period_q;
        pend_duty_d   = pend_duty_q;
        pend_valid_d  = pend_valid_q;
        pwm_out_d     = pwm_out_q;
        period_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                pwm_out_d = 1'b0;
                if (pend_valid_q) begin
                    act_period_d = pend_period_q;
                    act_duty_d   = pend_duty_q;
                    pend_valid_d = 1'b0;
                end
                // A zero period is not runnable; wait for a valid one.
                if (enable && (eff_period != '0)) begin
                    state_d   = ST_RUN;
                    pwm_out_d = (eff_duty != '0);
                end
            end

            ST_RUN, ST_STOP: begin
                // Enable may toggle freely until the wrap; STOP only differs there.
                state_d = enable ? ST_RUN : ST_STOP;
                if (tick) begin
                    if (counter_q == wrap_cnt) begin
                        counter_d     = '0;
                        period_done_d = 1'b1;
                        pwm_out_d     = (eff_duty != '0);
                        if (pend_valid_q) begin
                            act_period_d = pend_period_q;
                            act_duty_d   = pend_duty_q;
                            pend_valid_d = 1'b0;
                        end
                        if ((state_d == ST_STOP) || (eff_period == '0)) begin
                            state_d   = ST_IDLE;
                            pwm_out_d = 1'b0;
                        end
                    end else begin
                        counter_d = cnt_inc;
                        pwm_out_d = (cnt_inc < act_duty_q);
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                counter_d = '0;
                pwm_out_d = 1'b0;
            end
        endcase

        // Capture never coincides with a commit: the slot must be empty to accept.
        if (cfg_xfer) begin
            pend_period_d = cfg.cfg_period;
            pend_duty_d   = cfg.cfg_duty;
            pend_valid_d  = 1'b1;
        end
    end

    // State registers; reset discards any pending configuration.
    // NOTE: the shadow data is reset too, so a discarded slot never leaves X behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            counter_q     <= '0;
            act_period_q  <= '0;
            act_duty_q    <= '0;
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            pend_valid_q  <= 1'b0;
            pwm_out_q     <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            act_period_q  <= act_period_d;
            act_duty_q    <= act_duty_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            pend_valid_q  <= pend_valid_d;
            pwm_out_q     <= pwm_out_d;
            period_done_q <= period_done_d;
        end
    end

    assign cfg.cfg_ready = !pend_valid_q;
    assign pwm_out       = pwm_out_q;
    assign period_done   = period_done_q;
    assign busy          = (state_q != ST_IDLE);

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen. A divide-by-4 tick source drives the generator; a monitor
// measures each period window (period_done to period_done) and compares its
// length and high-cycle count against expectations queued by the scenarios.
module tb_pwm_gen;

    localparam int W = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic tick_in = 1'b0;
    logic enable  = 1'b0;
    logic pwm_out;
    logic period_done;
    logic busy;

    pwm_gen_if #(.CNT_WIDTH(W)) cfg_if ();

    pwm_gen #(.CNT_WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .enable      (enable),
        .cfg         (cfg_if),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int len;
        int high;
    } win_t;

    win_t sb[$];
    win_t mon_exp;

    // Upstream divider model, DIVISOR=4: tick_in rises every 4 clk; can be frozen.
    logic tick_hold = 1'b0;
    int   div_cnt   = 0;
    always @(negedge clk) begin
        if (!tick_hold) div_cnt = (div_cnt + 1) % 4;
        tick_in = (div_cnt < 2);
    end

    // Window monitor: closes a window at each period_done and checks it.
    bit in_win   = 1'b0;
    int win_len  = 0;
    int win_high = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_win = 1'b0;
        end else if (period_done === 1'b1) begin
            if (in_win && sb.size() > 0) begin
                mon_exp = sb.pop_front();
                total++;
                if (win_len !== mon_exp.len || win_high !== mon_exp.high) begin
                    bad++;
                    $display("FAIL period_window: got len=%0d high=%0d, want len=%0d high=%0d",
                             win_len, win_high, mon_exp.len, mon_exp.high);
                end
            end
            in_win   = 1'b1;
            win_len  = 1;
            win_high = (pwm_out === 1'b1) ? 1 : 0;
        end else if (in_win) begin
            win_len++;
            if (pwm_out === 1'b1) win_high++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_win(input int len, input int high);
        win_t w;
        w.len  = len;
        w.high = high;
        sb.push_back(w);
    endtask

    task automatic wait_pulse(input string what);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (period_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: period_done=0 for 200 cycles, want a pulse", what);
        end
    endtask

    task automatic wait_drain(input string what);
        for (int i = 0; i < 400 && sb.size() > 0; i++) step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d windows still pending after 400 cycles, want 0", what, sb.size());
            sb.delete();
        end
    endtask

    task automatic send_cfg(input int p, input int d);
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL cfg_ready_before_send: got %b want 1", cfg_if.cfg_ready);
        end
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = W'(p);
        cfg_if.cfg_duty   = W'(d);
        step();
        cfg_if.cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        total++;
        if (period_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", period_done); end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cfg_if.cfg_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_basic();
        send_cfg(4, 1);
        repeat (2) step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
        enable = 1'b1;
        wait_pulse("basic_first_wrap");
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        total++;
        if (pwm_out !== 1'b1) begin bad++; $display("FAIL basic_pwm_at_wrap: got %b want 1", pwm_out); end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", cfg_if.cfg_ready); end
        repeat (3) push_win(16, 4);
        wait_drain("basic");
    endtask

    task automatic test_reconfig();
        bit seen = 1'b0;
        int ready_bad = 0;
        repeat (5) step();
        push_win(16, 4);
        push_win(32, 24);
        push_win(32, 24);
        send_cfg(8, 6);
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL reconfig_ready_drop: got %b want 0", cfg_if.cfg_ready); end
        for (int i = 0; i < 40; i++) begin
            step();
            if (period_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (cfg_if.cfg_ready !== 1'b0) ready_bad++;
        end
        total++;
        if (!seen || ready_bad != 0) begin
            bad++;
            $display("FAIL reconfig_pending: wrap_seen=%0d ready_high_cycles=%0d, want 1 and 0", seen, ready_bad);
        end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reconfig_ready_return: got %b want 1", cfg_if.cfg_ready); end
        wait_drain("reconfig");
    endtask

    task automatic test_duty_extremes();
        push_win(32, 24);
        push_win(16, 0);
        push_win(16, 0);
        send_cfg(4, 0);
        wait_drain("duty_zero");
        push_win(16, 0);
        push_win(16, 16);
        push_win(16, 16);
        send_cfg(4, 5);
        wait_drain("duty_over_period");
    endtask

    task automatic test_hold_tick();
        push_win(16, 16);
        push_win(16, 4);
        send_cfg(4, 1);
        wait_drain("hold_setup");
        push_win(36, 24);
        push_win(16, 4);
        repeat (2) step();
        tick_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (pwm_out !== 1'b1 || period_done !== 1'b0) begin
                bad++;
                $display("FAIL hold_tick cycle %0d: got pwm=%b done=%b, want pwm=1 done=0", i, pwm_out, period_done);
            end
        end
        tick_hold = 1'b0;
        wait_drain("hold_tick");
    endtask

    task automatic test_stop();
        bit seen = 1'b0;
        push_win(16, 4);
        for (int i = 0; i < 40; i++) begin
            step();
            if (pwm_out === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL stop_tick1: pwm never fell within 40 cycles, want fall at tick 1"); end
        enable = 1'b0;
        step();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy_in_stop: got %b want 1", busy); end
        wait_pulse("stop_wrap");
        total++;
        if (pwm_out !== 1'b0) begin bad++; $display("FAIL stop_pwm_after_wrap: got %b want 0", pwm_out); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy_after_wrap: got %b want 0", busy); end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (pwm_out !== 1'b0 || period_done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL stop_idle cycle %0d: got pwm=%b done=%b busy=%b, want 0 0 0", i, pwm_out, period_done, busy);
            end
        end
    endtask

    task automatic test_period_zero();
        send_cfg(0, 2);
        repeat (2) step();
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (busy !== 1'b0 || pwm_out !== 1'b0 || period_done !== 1'b0) begin
                bad++;
                $display("FAIL period_zero cycle %0d: got busy=%b pwm=%b done=%b, want 0 0 0", i, busy, pwm_out, period_done);
            end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        send_cfg(4, 1);
        step();
        enable = 1'b1;
        wait_pulse("reset_mid_run");
        send_cfg(8, 2);
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_mid_pending: got ready=%b want 0", cfg_if.cfg_ready); end
        total++;
        if (pwm_out !== 1'b1) begin bad++; $display("FAIL reset_mid_pwm_before: got %b want 1", pwm_out); end
        rst_n = 1'b0;
        #1;
        total++;
        if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_mid_pwm: got %b want 0", pwm_out); end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_ready: got %b want 1", cfg_if.cfg_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (busy !== 1'b0 || pwm_out !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_mid_after cycle %0d: got busy=%b pwm=%b ready=%b, want 0 0 1",
                         i, busy, pwm_out, cfg_if.cfg_ready);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_duty   = '0;
        test_reset();
        test_basic();
        test_reconfig();
        test_duty_extremes();
        test_hold_tick();
        test_stop();
        test_period_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_gen

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Downstream consumer of the divided clock from the team's clock divider.
- Treats the divided clock as a slow tick and generates a programmable-period, programmable-duty PWM waveform in the fast clk domain.
- Configuration is taken through a valid/ready handshake and held in shadow registers, committed only at period boundaries so the output never glitches.
- Feeds LED dimmers and motor-enable pins.

Parameters:
- CNT_WIDTH, 8, width of the period/duty values and the internal tick counter.

Ports:
- clk  input  1  system clock; same clock that drives the upstream divider.
- rst_n  input  1  asynchronous, active-low reset.
- tick_in  input  1  divided clock from the upstream divider; registered in the clk domain, so no synchroniser is needed.
- enable  input  1  run request; level-sensitive.
- cfg_valid  input  1  new configuration offered.
- cfg_ready  output  1  pending slot free; a transfer occurs when cfg_valid && cfg_ready.
- cfg_period  input  CNT_WIDTH  ticks per PWM period; 0 is an invalid period.
- cfg_duty  input  CNT_WIDTH  ticks high per period.
- pwm_out  output  1  registered PWM output.
- period_done  output  1  1-cycle pulse at each period wrap.
- busy  output  1  high in RUN or STOP.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, counter=0, tick_d=0.
  - act_period=0, act_duty=0, pend_valid=0.
  - pwm_out=0, period_done=0, cfg_ready=1, busy=0.
- Tick detect: tick = tick_in && !tick_d. tick_d <= tick_in every cycle. Only rising edges of tick_in advance the counter.
- Config handshake:
  - cfg_ready = !pend_valid.
  - On transfer, capture cfg_period and cfg_duty into pend regs and set pend_valid.
  - cfg_valid while cfg_ready=0 is ignored; the sender holds until ready.
- Commit (pend -> act, then clear pend_valid):
  - In IDLE: the cycle after capture.
  - In RUN/STOP: only on a wrap tick.
  - cfg_ready returns to 1 the cycle after commit.
  - A new capture cannot coincide with a commit, because ready=0 while pending.
- State IDLE:
  - counter=0, pwm_out=0.
  - If enable=1 and act_period!=0: go to RUN, counter<=0, pwm_out<=(0<act_duty).
  - If enable=1 and act_period==0: stay in IDLE.
- State RUN, on each tick:
  - If counter==act_period-1 (wrap): counter<=0, period_done<=1, commit pending if present, pwm_out<=(0<new act_duty).
  - Otherwise: counter<=counter+1, pwm_out<=(counter+1<act_duty).
  - If enable=0 sampled in RUN: go to STOP.
- State STOP:
  - Identical tick behaviour to RUN, so the current period completes.
  - On wrap: go to IDLE and force pwm_out<=0.
  - If enable returns to 1 before the wrap: go back to RUN with no disturbance.
- Latency: pwm_out and counter change on the clk edge following the cycle in which a tick is detected, i.e. 1 clk after tick_in is seen high.
- Duty rules (compare is unsigned, CNT_WIDTH bits):
  - act_duty=0: pwm_out constant 0.
  - act_duty>=act_period: pwm_out constant 1 while running.
- Period 1: every tick is a wrap; period_done pulses on every tick.
- Without a tick, counter and pwm_out hold their values.
- period_done is high only for the single cycle after a wrap tick.
- Reset mid-period: all registers return to reset values immediately; pending config is discarded.

Decomposition:
- Shared package pwm_pkg:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_STOP=2'd2.
  - Default CNT_WIDTH.
- Sub-module tick_edge_det:
  - Registers tick_in and emits the 1-cycle rising-edge pulse.
  - Reusable by other consumers of divider outputs.
- Top pwm_gen contains the FSM, counter, shadow registers and handshake.

Test Plan:
- Setup for all scenarios: upstream divider runs with DIVISOR=4, so tick_in rises every 4 clk.
- Config period=4, duty=1, then enable=1 -> pwm_out high for 4 clk out of every 16; period_done pulses every 16 clk; busy=1.
- While running period=4/duty=1, send period=8/duty=6 mid-period -> cfg_ready drops to 0; the current period finishes at duty 1; the next period is 8 ticks with 6 high; cfg_ready returns to 1 the cycle after the wrap.
- duty=0 gives pwm_out always 0; duty=5 with period=4 gives pwm_out always 1; period=0 with enable=1 keeps state IDLE and busy=0.
- Deassert enable at tick 1 of a period=4 run -> the period completes (3 more ticks), period_done pulses, then pwm_out=0 and busy=0.
- Pulse rst_n low mid-period while pend_valid=1 -> pwm_out=0 and cfg_ready=1 immediately; after release, enable=1 stays IDLE because act_period=0.
- Hold tick_in constant for 20 clk -> counter and pwm_out unchanged, no period_done.
